// File: rtl/led_pio_pkg.sv
// Shared types and constants for the LED PIO write/verify arbiter.
package led_pio_pkg;
  localparam int          LED_W           = 16;
  localparam int          AVL_DW          = 32;
  localparam logic [15:0] RESET_VALUE_DEF = 16'h3136;
  localparam logic [1:0]  PIO_ADDR_DEF    = 2'd0;

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY} state_t;
endpackage

// File: rtl/led_pio_arbiter_if.sv
// Avalon-MM s1-style bus between the arbiter (master) and the LED PIO (slave).
interface led_pio_arbiter_if;
  import led_pio_pkg::*;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [AVL_DW-1:0] writedata;
  logic [AVL_DW-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  always_comb begin : pick
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/led_pio_arbiter.sv
// Shares the LED PIO between NUM_REQ requesters: each grant is one write then
// one read-back verify; keeps an LED mirror and a sticky verify error.
module led_pio_arbiter
  import led_pio_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter logic [15:0] RESET_VALUE = RESET_VALUE_DEF,
  parameter logic [1:0]  PIO_ADDR    = PIO_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [LED_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  led_pio_arbiter_if.master        pio,
  output logic [LED_W-1:0]         led_mirror,
  output logic                     busy,
  output logic                     verify_err,
  input  logic                     err_clr
);
  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, gidx_q, gidx;
  logic [NUM_REQ-1:0] gnt, grant_q;
  logic [LED_W-1:0]   wdata_q;
  logic               mismatch;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  // Any nonzero upper half counts as a mismatch too.
  assign mismatch = (pio.readdata != {{(AVL_DW-LED_W){1'b0}}, wdata_q});
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    pio.address    = PIO_ADDR;
    pio.chipselect = 1'b0;
    pio.write_n    = 1'b1;
    pio.writedata  = '0;
    req_ready      = '0;
    case (state_q)
      IDLE:   if (|req_valid) state_d = WRITE;
      WRITE: begin
        pio.chipselect = 1'b1;
        pio.write_n    = 1'b0;
        pio.writedata  = {{(AVL_DW-LED_W){1'b0}}, wdata_q};
        state_d        = VERIFY;
      end
      VERIFY: begin
        pio.chipselect = 1'b1;
        req_ready      = grant_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      wdata_q    <= '0;
      led_mirror <= RESET_VALUE;
      verify_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_valid) begin
        grant_q <= gnt;
        gidx_q  <= gidx;
        wdata_q <= req_data[LED_W*gidx +: LED_W];
      end
      if (state_q == VERIFY) begin
        led_mirror <= mismatch ? pio.readdata[LED_W-1:0] : wdata_q;
        ptr_q      <= (int'(gidx_q) == NUM_REQ-1) ? '0 : gidx_q + 1'b1;
      end
      // A new mismatch outranks a simultaneous clear.
      if (state_q == VERIFY && mismatch) verify_err <= 1'b1;
      else if (err_clr)                  verify_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_pio_arbiter.sv
// Randomized + directed bench for led_pio_arbiter against a transaction-level model.
module tb_led_pio_arbiter;
  import led_pio_pkg::*;
  localparam int          N  = 3;
  localparam logic [15:0] RV = 16'h3136;

  logic            clk = 1'b0, reset_n = 1'b0, err_clr = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, pend = '0;
  logic [16*N-1:0] req_data = '0;
  logic [15:0]     led_mirror, led_reg;
  logic            busy, verify_err;
  logic            force_en = 1'b0, inject = 1'b0;
  logic [31:0]     force_val = '0;

  led_pio_arbiter_if pio();

  led_pio_arbiter #(.NUM_REQ(N), .RESET_VALUE(RV), .PIO_ADDR(2'd0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pio(pio), .led_mirror(led_mirror), .busy(busy),
    .verify_err(verify_err), .err_clr(err_clr)
  );

  // PIO slave stand-in; readdata can be overridden to inject a bad read-back.
  assign pio.readdata = force_en ? force_val : {16'h0, led_reg};
  always @(posedge clk or negedge reset_n)
    if (!reset_n) led_reg <= RV;
    else if (pio.chipselect && !pio.write_n) led_reg <= pio.writedata[15:0];

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction model: phase 0 = waiting, 1 = write beat, 2 = verify beat.
  int          m_phase, m_g, m_ptr;
  logic [15:0] m_data, m_mirror, m_led;
  logic        m_err;
  int          grants[$];

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ptr = 0; m_data = '0;
    m_mirror = RV; m_led = RV; m_err = 1'b0;
  endtask

  // Called at a negedge with inputs set; checks this cycle, advances model, returns at next negedge.
  task automatic step();
    logic [31:0] rd;
    logic        mm;
    force_en = (m_phase == 2) && inject;
    #1;
    chk("busy",   32'(busy),           32'(m_phase != 0));
    chk("ready",  32'(req_ready),      (m_phase == 2) ? (32'd1 << m_g) : 32'd0);
    chk("cs",     32'(pio.chipselect), 32'(m_phase != 0));
    chk("wr_n",   32'(pio.write_n),    32'(m_phase != 1));
    chk("addr",   32'(pio.address),    32'd0);
    chk("wdata",  pio.writedata,       (m_phase == 1) ? {16'h0, m_data} : 32'd0);
    chk("mirror", 32'(led_mirror),     32'(m_mirror));
    chk("err",    32'(verify_err),     32'(m_err));
    mm = 1'b0;
    case (m_phase)
      0: if (req_valid != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        m_data  = req_data[16*m_g +: 16];
        m_phase = 1;
      end
      1: begin m_led = m_data; m_phase = 2; end
      default: begin
        grants.push_back(m_g);
        rd = force_en ? force_val : {16'h0, m_led};
        mm = (rd != {16'h0, m_data});
        m_mirror = mm ? rd[15:0] : m_data;
        if (mm) m_err = 1'b1;
        m_ptr   = (m_g + 1) % N;
        m_phase = 0;
      end
    endcase
    if (!mm && err_clr) m_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_busy",   32'(busy),           32'd0);
    chk("rst_ready",  32'(req_ready),      32'd0);
    chk("rst_cs",     32'(pio.chipselect), 32'd0);
    chk("rst_mirror", 32'(led_mirror),     32'(RV));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    repeat (10) step();
    chk("idle_mirror", 32'(led_mirror), 32'h3136);

    // Single request from requester 0.
    req_data[15:0] = 16'h00FF; req_valid = 3'b001;
    step();
    chk("t1_wdata", pio.writedata, 32'h0000_00FF);
    step();
    chk("t2_ready", 32'(req_ready), 32'b001);
    req_valid = '0;
    step();
    chk("t2_mirror", 32'(led_mirror), 32'h00FF);

    // Two requesters held continuously: grants alternate.
    req_data[15:0] = 16'hAAAA; req_data[31:16] = 16'h5555; req_valid = 3'b011;
    p0 = m_ptr;
    grants.delete();
    repeat (12) step();
    req_valid = '0;
    chk("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", 32'(grants[k]), 32'((p0 + k) % 2));
      chk("rr_last", 32'(led_reg), (grants[3] == 0) ? 32'hAAAA : 32'h5555);
    end

    // Bad read-back, then clear.
    req_data[15:0] = 16'h00FF; req_valid = 3'b001; force_val = 32'h1234; inject = 1'b1;
    step(); step();
    req_valid = '0;
    step();
    inject = 1'b0;
    chk("mm_err", 32'(verify_err), 32'd1);
    chk("mm_mirror", 32'(led_mirror), 32'h1234);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_err", 32'(verify_err), 32'd0);

    // Clear coincident with a mismatch: set wins.
    req_valid = 3'b001; inject = 1'b1; force_val = 32'h0001_00FF;
    step(); step();
    req_valid = '0; err_clr = 1'b1;
    step();
    err_clr = 1'b0; inject = 1'b0;
    chk("set_wins", 32'(verify_err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Reset during the write beat; request is re-served afterwards.
    req_data[15:0] = 16'hBEEF; req_valid = 3'b001;
    step();
    chk("pre_rst_wr_n", 32'(pio.write_n), 32'd0);
    do_reset();
    step(); step();
    req_valid = '0;
    step();
    chk("reserve", 32'(led_mirror), 32'hBEEF);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_phase != 0 && m_g == i) begin
          req_valid[i] = ($urandom_range(7) != 0);
          if (m_phase == 2) pend[i] = 1'b0;
        end else if (pend[i]) req_valid[i] = 1'b1;
        else begin
          pend[i] = ($urandom_range(2) == 0);
          req_valid[i] = pend[i];
        end
        if ($urandom_range(3) == 0) req_data[16*i +: 16] = 16'($urandom);
      end
      inject    = ($urandom_range(4) == 0);
      force_val = ($urandom_range(1) == 0) ? 32'($urandom) : {16'h0, 16'($urandom)};
      err_clr   = ($urandom_range(9) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
